// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default sizing.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2
    } arb_state_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int RAM_AW_DEF     = 12;
    localparam int CNT_W          = 4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Starvation guard: counts CPU wins while the external port waits and forces
// an external grant once the count reaches STARVE_MAX.
module dmem_arb_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_req_i,
    input  logic cpu_gnt_i,
    input  logic ext_gnt_i,
    output logic ext_force_o
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!ext_req_i || ext_gnt_i) begin
            cnt_d = '0;
        end else if (cpu_gnt_i && (cnt_q < MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ext_force_o = ext_req_i && (cnt_q == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the MEM-stage CPU port and a loader/debug port onto one
// synchronous-read RAM. Optional alignment trap: define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int RAM_AW     = RAM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [31:0]       ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic              ext_ack,
    output logic [31:0]       ext_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              align_err
);

    arb_state_e state_q, state_d;
    logic       ext_ack_q;
    logic       ext_force;
    logic       misal;
    logic       idle, ext_win, ext_gnt, cpu_gnt, cpu_ram;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[31:RAM_AW+2], cpu_addr[1:0],
                                ext_addr[31:RAM_AW+2], ext_addr[1:0]};

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic align_err_q;
    assign misal = is_misaligned(cpu_addr);
`else
    assign misal = 1'b0;
`endif

    // An ack in the previous cycle blocks an ext grant so acks never abut.
    assign idle    = (state_q == IDLE) && !rst;
    assign ext_win = ext_req && !ext_ack_q && (ext_force || !cpu_ce);
    assign ext_gnt = idle && ext_win;
    assign cpu_gnt = idle && cpu_ce && !ext_win;
    assign cpu_ram = cpu_gnt && !misal;

    dmem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .ext_req_i   (ext_req),
        .cpu_gnt_i   (cpu_gnt),
        .ext_gnt_i   (ext_gnt),
        .ext_force_o (ext_force)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ext_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ext_ack_q <= ext_ack;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ext_gnt && !ext_we) begin
                    state_d = EXT_RD;
                end else if (cpu_ram && !cpu_we) begin
                    state_d = CPU_RD;
                end
            end
            CPU_RD:  state_d = IDLE;
            EXT_RD:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        cpu_rdata = '0;
        cpu_stall = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (ext_gnt) begin
                        ram_ce    = 1'b1;
                        ram_we    = ext_we;
                        ram_addr  = ext_addr[RAM_AW+1:2];
                        ram_wdata = ext_wdata;
                        ext_ack   = ext_we;
                        cpu_stall = cpu_ce;
                    end else if (cpu_ram) begin
                        ram_ce    = 1'b1;
                        ram_we    = cpu_we;
                        ram_addr  = cpu_addr[RAM_AW+1:2];
                        ram_wdata = cpu_wdata;
                        cpu_stall = !cpu_we;
                    end
                end
                CPU_RD: begin
                    cpu_rdata = ram_rdata;
                end
                EXT_RD: begin
                    ext_ack   = 1'b1;
                    ext_rdata = ram_rdata;
                    cpu_stall = cpu_ce;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else if (cpu_gnt && misal) begin
            align_err_q <= 1'b1;
        end
    end
    assign align_err = align_err_q;
`else
    assign align_err = 1'b0;
`endif

endmodule
